pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
//
// Hazard and stall/flush controller for a five-stage in-order pipeline
// (IF / ID / EX / MEM / WB).
//
// The controller arbitrates three sources of pipeline disturbance, in this
// priority order:
//   1. A memory/MMIO access in MEM that has not completed (memory wait).
//      This freezes the whole pipeline.
//   2. A taken branch or jump resolved in EX.
//      This flushes IF/ID and ID/EX.
//   3. A load-use hazard between the load in EX and the instruction in ID.
//      This holds PC and IF/ID for one cycle and puts a bubble into ID/EX.
//
// A lower-priority event that coincides with a higher-priority one is
// dropped. It is not queued for a later cycle.
//
// All stall and flush outputs are combinational from the registered state
// and the current inputs, so they act in the same cycle.
//
// Two saturating performance counters are provided:
//   StallCycles : counts cycles with PcStall=1
//   FlushEvents : counts cycles with any flush output asserted
//
// Build option:
//   PIPELINE_CTRL_MEM_TIMEOUT_EN
//     When this macro is defined, a memory wait is aborted after
//     TIMEOUT_CYCLES cycles in MEM_WAIT. The abort pulses MemErr and
//     ExMemFlush and returns the controller to RUN.
//     When it is undefined, MEM_WAIT lasts until MemReady, and MemErr and
//     ExMemFlush are tied low.
//
// Parameters:
//   TIMEOUT_CYCLES : MEM_WAIT cycles before an abort (timeout build only)
//   CNT_W          : width of the performance counters
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   IdRs1, IdRs2               source registers of the instruction in ID
//   IdUseRs1, IdUseRs2         the ID instruction actually reads Rs1 / Rs2
//   ExMemRead, ExRd            the EX instruction is a load, and its
//                              destination register
//   ExBranchTaken              taken branch/jump resolved in EX
//   MemReq, MemReady           MEM access in progress / access completes
//   *Stall                     hold the PC or the named pipeline register
//   *Flush                     load a bubble into the named pipeline register
//   MemBusy                    controller is in MEM_WAIT
//   MemErr                     one-cycle memory-timeout pulse
//   StallCycles, FlushEvents   performance counters
//
// States:
//   RUN       normal flow; branch and load-use handling are active
//   MEM_WAIT  an outstanding MEM access is not done; pipeline frozen
// ----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255,
    parameter int         CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [4:0]       IdRs1,
    input  logic [4:0]       IdRs2,
    input  logic             IdUseRs1,
    input  logic             IdUseRs2,
    input  logic             ExMemRead,
    input  logic [4:0]       ExRd,
    input  logic             ExBranchTaken,
    input  logic             MemReq,
    input  logic             MemReady,

    output logic             PcStall,
    output logic             IfIdStall,
    output logic             IdExStall,
    output logic             ExMemStall,
    output logic             MemWbStall,
    output logic             IfIdFlush,
    output logic             IdExFlush,
    output logic             ExMemFlush,
    output logic             MemBusy,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushEvents
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_load_use;
    logic             w_mem_wait;
    logic             w_any_flush;

`ifdef PIPELINE_CTRL_MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = TIMEOUT_CYCLES - 8'd1;

    logic [7:0]       r_tmo_cnt;
    logic             w_timeout;
`endif

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------

    // A load whose destination is x0 can never create a hazard, because
    // x0 always reads as zero.
    assign w_load_use = ExMemRead && (ExRd != 5'd0) &&
                        ((IdUseRs1 && (IdRs1 == ExRd)) ||
                         (IdUseRs2 && (IdRs2 == ExRd)));

    assign w_mem_wait = ((r_state == ST_RUN)      && MemReq && !MemReady) ||
                        ((r_state == ST_MEM_WAIT) && !MemReady);

`ifdef PIPELINE_CTRL_MEM_TIMEOUT_EN
    // If MemReady arrives on the last allowed cycle, the access completes
    // normally and no timeout is raised.
    assign w_timeout = (r_state == ST_MEM_WAIT) && !MemReady &&
                       (r_tmo_cnt == TMO_LAST);
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic and stall/flush outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        PcStall     = 1'b0;
        IfIdStall   = 1'b0;
        IdExStall   = 1'b0;
        ExMemStall  = 1'b0;
        MemWbStall  = 1'b0;
        IfIdFlush   = 1'b0;
        IdExFlush   = 1'b0;
        ExMemFlush  = 1'b0;
        MemErr      = 1'b0;
        MemBusy     = 1'b0;

        // While rst is asserted, every output is held quiet, even though the
        // hazard inputs may be active.
        if (!rst) begin
            MemBusy = (r_state == ST_MEM_WAIT);

`ifdef PIPELINE_CTRL_MEM_TIMEOUT_EN
            if (w_timeout) begin
                // Abort the access. The faulting instruction in EX/MEM is
                // dropped, and the pipeline restarts from RUN.
                MemErr      = 1'b1;
                ExMemFlush  = 1'b1;
                w_state_nxt = ST_RUN;
            end else
`endif
            if (w_mem_wait) begin
                PcStall     = 1'b1;
                IfIdStall   = 1'b1;
                IdExStall   = 1'b1;
                ExMemStall  = 1'b1;
                MemWbStall  = 1'b1;
                w_state_nxt = ST_MEM_WAIT;
            end else if (r_state == ST_MEM_WAIT) begin
                // The access completes this cycle. Branch and load-use
                // handling are only active in RUN, so nothing else happens.
                w_state_nxt = ST_RUN;
            end else if (ExBranchTaken) begin
                IfIdFlush = 1'b1;
                IdExFlush = 1'b1;
            end else if (w_load_use) begin
                PcStall   = 1'b1;
                IfIdStall = 1'b1;
                IdExFlush = 1'b1;
            end
        end
    end

`ifdef PIPELINE_CTRL_MEM_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Memory timeout counter
    //   - Cleared when the controller enters MEM_WAIT.
    //   - Counts each MEM_WAIT cycle in which MemReady is low.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= 8'd0;
        end else if ((r_state == ST_RUN) && (w_state_nxt == ST_MEM_WAIT)) begin
            r_tmo_cnt <= 8'd0;
        end else if ((r_state == ST_MEM_WAIT) && !MemReady) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Performance counters (saturating at all-ones)
    // ------------------------------------------------------------------------
    assign w_any_flush = IfIdFlush || IdExFlush || ExMemFlush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (PcStall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_any_flush && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign StallCycles = r_stall_cnt;
    assign FlushEvents = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl.
//
// The driver applies one input vector per cycle, 1 time unit after the rising
// edge. It asks a reference model for that cycle's expected outputs and
// pushes them onto a queue.
//
// The monitor samples the DUT on the falling edge and compares the samples
// with the popped expectation.
//
// A second instance with 2-bit counters shares the same stimulus, so that
// counter saturation is exercised quickly.
module tb_pipeline_ctrl;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] IdRs1;
    logic [4:0] IdRs2;
    logic [4:0] ExRd;
    logic       IdUseRs1;
    logic       IdUseRs2;
    logic       ExMemRead;
    logic       ExBranchTaken;
    logic       MemReq;
    logic       MemReady;

    // Outputs of the 32-bit instance
    logic        PcStall, IfIdStall, IdExStall, ExMemStall, MemWbStall;
    logic        IfIdFlush, IdExFlush, ExMemFlush, MemBusy, MemErr;
    logic [31:0] StallCycles, FlushEvents;

    // Outputs of the 2-bit instance
    logic        s_ps, s_ifs, s_ids, s_ems, s_mws;
    logic        s_iff, s_idf, s_emf, s_busy, s_err;
    logic [1:0]  s_sc, s_fc;

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT_CYCLES(8'd4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .IdRs1(IdRs1), .IdRs2(IdRs2),
        .IdUseRs1(IdUseRs1), .IdUseRs2(IdUseRs2),
        .ExMemRead(ExMemRead), .ExRd(ExRd),
        .ExBranchTaken(ExBranchTaken),
        .MemReq(MemReq), .MemReady(MemReady),
        .PcStall(PcStall), .IfIdStall(IfIdStall), .IdExStall(IdExStall),
        .ExMemStall(ExMemStall), .MemWbStall(MemWbStall),
        .IfIdFlush(IfIdFlush), .IdExFlush(IdExFlush), .ExMemFlush(ExMemFlush),
        .MemBusy(MemBusy), .MemErr(MemErr),
        .StallCycles(StallCycles), .FlushEvents(FlushEvents)
    );

    pipeline_ctrl #(.TIMEOUT_CYCLES(8'd4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .IdRs1(IdRs1), .IdRs2(IdRs2),
        .IdUseRs1(IdUseRs1), .IdUseRs2(IdUseRs2),
        .ExMemRead(ExMemRead), .ExRd(ExRd),
        .ExBranchTaken(ExBranchTaken),
        .MemReq(MemReq), .MemReady(MemReady),
        .PcStall(s_ps), .IfIdStall(s_ifs), .IdExStall(s_ids),
        .ExMemStall(s_ems), .MemWbStall(s_mws),
        .IfIdFlush(s_iff), .IdExFlush(s_idf), .ExMemFlush(s_emf),
        .MemBusy(s_busy), .MemErr(s_err),
        .StallCycles(s_sc), .FlushEvents(s_fc)
    );

    // Output vector bit order:
    //   {PcStall, IfIdStall, IdExStall, ExMemStall, MemWbStall,
    //    IfIdFlush, IdExFlush, ExMemFlush, MemBusy, MemErr}
    typedef struct packed {
        logic [9:0]  o;
        logic [31:0] sc;
        logic [31:0] fc;
        logic [1:0]  sc2;
        logic [1:0]  fc2;
        logic [31:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cyc   = 0;

    // ------------------------------------------------------------------------
    // Reference model state, described in terms of the rules:
    //   m_wait : an access is still outstanding
    //   m_nw   : MEM_WAIT cycles already spent in the current wait
    //   m_sc*, m_fc* : counter values as plain integers
    // ------------------------------------------------------------------------
    bit          m_wait = 1'b0;
    int          m_nw   = 0;
    longint      m_sc   = 0;
    longint      m_fc   = 0;
    int          m_sc2  = 0;
    int          m_fc2  = 0;

    task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic ld,
                        input logic [4:0] rd, input logic br,
                        input logic req, input logic rdy);
        bit   lu, to, stall_all, lus, bfl;
        exp_t e;

        @(posedge clk);
        #1;
        rst       = r;
        IdRs1     = rs1;
        IdRs2     = rs2;
        IdUseRs1  = u1;
        IdUseRs2  = u2;
        ExMemRead = ld;
        ExRd      = rd;
        ExBranchTaken = br;
        MemReq    = req;
        MemReady  = rdy;

        e         = '0;
        e.id      = n_cyc;
        n_cyc++;

        if (r) begin
            // Asynchronous reset clears everything within this cycle.
            m_wait = 1'b0;
            m_nw   = 0;
            m_sc   = 0;
            m_fc   = 0;
            m_sc2  = 0;
            m_fc2  = 0;
        end else begin
            lu = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
            to = 1'b0;
`ifdef PIPELINE_CTRL_MEM_TIMEOUT_EN
            to = m_wait && !rdy && (m_nw == TMO - 1);
`endif
            stall_all = !to && !rdy && (m_wait || req);
            bfl = !to && !stall_all && !m_wait && br;
            lus = !to && !stall_all && !m_wait && !br && lu;

            e.o = {stall_all || lus, stall_all || lus, stall_all, stall_all, stall_all,
                   bfl, bfl || lus, to, m_wait, to};

            if (to) begin
                m_wait = 1'b0;
            end else if (stall_all) begin
                m_nw   = m_wait ? m_nw + 1 : 0;
                m_wait = 1'b1;
            end else begin
                m_wait = 1'b0;
            end
        end

        e.sc  = 32'(m_sc);
        e.fc  = 32'(m_fc);
        e.sc2 = 2'(m_sc2);
        e.fc2 = 2'(m_fc2);
        exp_q.push_back(e);

        if (e.o[9]) begin
            if (m_sc < 64'hFFFF_FFFF) m_sc++;
            if (m_sc2 < 3) m_sc2++;
        end
        if (e.o[4] || e.o[3] || e.o[2]) begin
            if (m_fc < 64'hFFFF_FFFF) m_fc++;
            if (m_fc2 < 3) m_fc2++;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t       e;
        logic [9:0] got;

        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {PcStall, IfIdStall, IdExStall, ExMemStall, MemWbStall,
                   IfIdFlush, IdExFlush, ExMemFlush, MemBusy, MemErr};

            n_tests++;
            if (got !== e.o) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d got=%b want=%b", e.id, got, e.o);
            end

            n_tests++;
            if (StallCycles !== e.sc) begin
                n_fail++;
                $display("FAIL StallCycles cyc=%0d got=%0d want=%0d", e.id, StallCycles, e.sc);
            end

            n_tests++;
            if (FlushEvents !== e.fc) begin
                n_fail++;
                $display("FAIL FlushEvents cyc=%0d got=%0d want=%0d", e.id, FlushEvents, e.fc);
            end

            n_tests++;
            if (s_sc !== e.sc2) begin
                n_fail++;
                $display("FAIL StallCycles_sat cyc=%0d got=%0d want=%0d", e.id, s_sc, e.sc2);
            end

            n_tests++;
            if (s_fc !== e.fc2) begin
                n_fail++;
                $display("FAIL FlushEvents_sat cyc=%0d got=%0d want=%0d", e.id, s_fc, e.fc2);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        IdRs1 = '0; IdRs2 = '0; ExRd = '0;
        IdUseRs1 = 0; IdUseRs2 = 0; ExMemRead = 0;
        ExBranchTaken = 0; MemReq = 0; MemReady = 1;

        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Load-use on Rs1
        step(0, 5, 0, 1, 0, 1, 5, 0, 0, 1);
        idle();

        // Load to x0: no hazard
        step(0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
        idle();

        // Branch and load-use together: branch wins
        step(0, 5, 0, 1, 0, 1, 5, 1, 0, 1);
        idle();

        // Load-use on Rs2 only
        step(0, 1, 7, 0, 1, 1, 7, 0, 0, 1);

        // Three wait cycles, then ready
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();

        // Long wait: times out in the timeout build, otherwise persists
        repeat (6) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();

        // Reset in the middle of a wait
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 3, 0, 1, 0, 1, 3, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // Stalls that drive the 2-bit counters into saturation
        repeat (5) step(0, 2, 0, 1, 0, 1, 2, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 299) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
        idle();

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain got=%0d want=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
